// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared decode constants for the RV32I decode stage: opcode and funct
// encodings, the ALU operation encoding carried on out_aluop, immediate
// selector type and the level constants used for illegal / enable flags.
// No ports (package).
// -----------------------------------------------------------------------------
package id_stage_pkg;

    // Major opcodes (inst[6:0]); every legal one ends in 2'b11, so a
    // compressed-style low pair never matches and falls into the illegal arm.
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // ALU funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Memory width codes (passed through on out_funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Branch condition codes (passed through on out_funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic ILLEGAL = 1'b1;
    localparam logic LEGAL   = 1'b0;
    localparam logic EN      = 1'b1;
    localparam logic DIS     = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // ALU op for the funct7=0 form of OP / OP-IMM.
    function automatic alu_op_e alu_base(input logic [2:0] f3);
        case (f3)
            F3_ADD_SUB: alu_base = ALU_ADD;
            F3_SLL:     alu_base = ALU_SLL;
            F3_SLT:     alu_base = ALU_SLT;
            F3_SLTU:    alu_base = ALU_SLTU;
            F3_XOR:     alu_base = ALU_XOR;
            F3_SR:      alu_base = ALU_SRL;
            F3_OR:      alu_base = ALU_OR;
            default:    alu_base = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// -----------------------------------------------------------------------------
// id_imm_gen
// Combinational immediate generator: builds the sign-extended I/S/B/U/J
// immediate from the instruction word.
// Ports:
//   inst_i      instruction bits [31:7] (opcode bits are not needed here)
//   imm_type_i  immediate format selector
//   imm_o       XLEN-wide sign-extended immediate (0 for IMM_NONE)
// -----------------------------------------------------------------------------
module id_imm_gen
    import id_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_type_i)
            IMM_I: imm_o = XLEN'($signed(inst_i[31:20]));
            IMM_S: imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
            IMM_B: imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                          inst_i[11:8], 1'b0}));
            IMM_U: imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
            IMM_J: imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                          inst_i[30:21], 1'b0}));
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// RV32I decode stage between IF/ID and ID/EX. Decodes in_inst, drives the
// synchronous regfile read ports, and registers the decoded control into a
// single output slot whose operands come straight from the regfile data
// (the regfile captures on the same edge that loads the slot). Stalls one
// cycle on a load-use dependency against its own slot; flush kills both the
// slot and the incoming instruction.
// Optional build macro: ID_STAGE_MEXT_EN adds RV32M decode and out_is_muldiv.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_inst/in_pc          upstream handshake
//   re1/re2/raddr1/raddr2, rdata1/rdata2     regfile read ports
//   out_valid/out_ready and out_* fields     ID/EX slot
// -----------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               re1,
    output logic               re2,
    output logic [REG_AW-1:0]  raddr1,
    output logic [REG_AW-1:0]  raddr2,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [REG_AW-1:0]  out_rs1,
    output logic [REG_AW-1:0]  out_rs2,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_rd_we,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_use_imm,
    output logic [XLEN-1:0]    out_op1,
    output logic [XLEN-1:0]    out_op2,
    output logic               out_is_load,
    output logic               out_is_store,
    output logic               out_is_branch,
    output logic               out_is_jump,
    output logic [2:0]         out_funct3,
`ifdef ID_STAGE_MEXT_EN
    output logic               out_is_muldiv,
`endif
    output logic               out_illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd_d   = REG_AW'(in_inst[11:7]);
    assign rs1_d  = REG_AW'(in_inst[19:15]);
    assign rs2_d  = REG_AW'(in_inst[24:20]);

    logic            rs1_used_d, rs2_used_d, rd_we_d, use_imm_d;
    logic            is_load_d, is_store_d, is_branch_d, is_jump_d, illegal_d;
    logic [3:0]      aluop_d;
    imm_type_e       imm_type_d;
    logic [XLEN-1:0] imm_d;
`ifdef ID_STAGE_MEXT_EN
    logic            is_muldiv_d;
`endif

    always_comb begin
        rs1_used_d  = DIS;
        rs2_used_d  = DIS;
        rd_we_d     = DIS;
        use_imm_d   = DIS;
        is_load_d   = 1'b0;
        is_store_d  = 1'b0;
        is_branch_d = 1'b0;
        is_jump_d   = 1'b0;
        illegal_d   = LEGAL;
        aluop_d     = ALU_ADD;
        imm_type_d  = IMM_NONE;
`ifdef ID_STAGE_MEXT_EN
        is_muldiv_d = 1'b0;
`endif
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                rd_we_d    = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_U;
            end
            OPC_JAL: begin
                is_jump_d  = 1'b1;
                rd_we_d    = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_J;
            end
            OPC_JALR: begin
                is_jump_d  = 1'b1;
                rs1_used_d = EN;
                rd_we_d    = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_I;
            end
            OPC_BRANCH: begin
                is_branch_d = 1'b1;
                rs1_used_d  = EN;
                rs2_used_d  = EN;
                imm_type_d  = IMM_B;
                aluop_d     = ALU_SUB;
            end
            OPC_LOAD: begin
                is_load_d  = 1'b1;
                rs1_used_d = EN;
                rd_we_d    = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_I;
            end
            OPC_STORE: begin
                is_store_d = 1'b1;
                rs1_used_d = EN;
                rs2_used_d = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_S;
            end
            OPC_OP_IMM: begin
                rs1_used_d = EN;
                rd_we_d    = EN;
                use_imm_d  = EN;
                imm_type_d = IMM_I;
                aluop_d    = alu_base(funct3);
                // Shift-immediates reuse imm[11:5] as a funct7 that must be valid.
                if (funct3 == F3_SLL && funct7 != F7_BASE) begin
                    illegal_d = ILLEGAL;
                end
                if (funct3 == F3_SR) begin
                    if (funct7 == F7_ALT) begin
                        aluop_d = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        illegal_d = ILLEGAL;
                    end
                end
            end
            OPC_OP: begin
                rs1_used_d = EN;
                rs2_used_d = EN;
                rd_we_d    = EN;
                if (funct7 == F7_BASE) begin
                    aluop_d = alu_base(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    aluop_d = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    aluop_d = ALU_SRA;
`ifdef ID_STAGE_MEXT_EN
                end else if (funct7 == F7_MULDIV) begin
                    is_muldiv_d = 1'b1;
                    aluop_d     = {1'b0, funct3};
`endif
                end else begin
                    illegal_d = ILLEGAL;
                end
            end
            OPC_FENCE: begin
                // No memory ordering to enforce in this pipeline: plain NOP.
                aluop_d = ALU_ADD;
            end
            OPC_SYSTEM: begin
                if (in_inst != INST_ECALL && in_inst != INST_EBREAK) begin
                    illegal_d = ILLEGAL;
                end
            end
            default: illegal_d = ILLEGAL;
        endcase

        // An illegal word must not write, read or look like any class.
        if (illegal_d == ILLEGAL) begin
            rd_we_d     = DIS;
            rs1_used_d  = DIS;
            rs2_used_d  = DIS;
            use_imm_d   = DIS;
            is_load_d   = 1'b0;
            is_store_d  = 1'b0;
            is_branch_d = 1'b0;
            is_jump_d   = 1'b0;
            aluop_d     = ALU_ADD;
            imm_type_d  = IMM_NONE;
        end
        if (rd_d == '0) begin
            rd_we_d = DIS;
        end
    end

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst_i     (in_inst[31:7]),
        .imm_type_i (imm_type_d),
        .imm_o      (imm_d)
    );

    logic               out_valid_q, out_rd_we_q, out_use_imm_q;
    logic               out_is_load_q, out_is_store_q, out_is_branch_q, out_is_jump_q;
    logic               out_illegal_q, rs1_used_q, rs2_used_q;
    logic [XLEN-1:0]    out_pc_q, out_imm_q;
    logic [REG_AW-1:0]  out_rs1_q, out_rs2_q, out_rd_q;
    logic [ALUOP_W-1:0] out_aluop_q;
    logic [2:0]         out_funct3_q;
`ifdef ID_STAGE_MEXT_EN
    logic               out_is_muldiv_q;
`endif

    logic hazard, accept;

    // x0 as a load target carries no data, so it never creates a dependency.
    assign hazard = out_valid_q && out_is_load_q && (out_rd_q != '0) &&
                    ((rs1_used_d && rs1_d == out_rd_q) ||
                     (rs2_used_d && rs2_d == out_rd_q));

    assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign re1      = accept && rs1_used_d;
    assign re2      = accept && rs2_used_d;
    assign raddr1   = rs1_d;
    assign raddr2   = rs2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_rs1_q       <= '0;
            out_rs2_q       <= '0;
            out_rd_q        <= '0;
            out_rd_we_q     <= 1'b0;
            out_aluop_q     <= '0;
            out_imm_q       <= '0;
            out_use_imm_q   <= 1'b0;
            out_is_load_q   <= 1'b0;
            out_is_store_q  <= 1'b0;
            out_is_branch_q <= 1'b0;
            out_is_jump_q   <= 1'b0;
            out_funct3_q    <= '0;
            out_illegal_q   <= 1'b0;
            rs1_used_q      <= 1'b0;
            rs2_used_q      <= 1'b0;
`ifdef ID_STAGE_MEXT_EN
            out_is_muldiv_q <= 1'b0;
`endif
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q     <= 1'b1;
            out_pc_q        <= in_pc;
            out_rs1_q       <= rs1_d;
            out_rs2_q       <= rs2_d;
            out_rd_q        <= rd_d;
            out_rd_we_q     <= rd_we_d;
            out_aluop_q     <= ALUOP_W'(aluop_d);
            out_imm_q       <= imm_d;
            out_use_imm_q   <= use_imm_d;
            out_is_load_q   <= is_load_d;
            out_is_store_q  <= is_store_d;
            out_is_branch_q <= is_branch_d;
            out_is_jump_q   <= is_jump_d;
            out_funct3_q    <= funct3;
            out_illegal_q   <= illegal_d;
            rs1_used_q      <= rs1_used_d;
            rs2_used_q      <= rs2_used_d;
`ifdef ID_STAGE_MEXT_EN
            out_is_muldiv_q <= is_muldiv_d;
`endif
        end else if (out_ready || !out_valid_q) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_rs1       = out_rs1_q;
    assign out_rs2       = out_rs2_q;
    assign out_rd        = out_rd_q;
    assign out_rd_we     = out_rd_we_q;
    assign out_aluop     = out_aluop_q;
    assign out_imm       = out_imm_q;
    assign out_use_imm   = out_use_imm_q;
    assign out_is_load   = out_is_load_q;
    assign out_is_store  = out_is_store_q;
    assign out_is_branch = out_is_branch_q;
    assign out_is_jump   = out_is_jump_q;
    assign out_funct3    = out_funct3_q;
    assign out_illegal   = out_illegal_q;
`ifdef ID_STAGE_MEXT_EN
    assign out_is_muldiv = out_is_muldiv_q;
`endif
    // Regfile holds its data while re is low, so these stay stable under stall.
    assign out_op1 = rs1_used_q ? rdata1 : '0;
    assign out_op2 = rs2_used_q ? rdata2 : '0;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, re1, re2, out_valid;
    logic [4:0]  raddr1, raddr2, out_rs1, out_rs2, out_rd;
    logic [31:0] rdata1 = '0, rdata2 = '0;
    logic [31:0] out_pc, out_imm, out_op1, out_op2;
    logic        out_rd_we, out_use_imm, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal;
    logic [3:0]  out_aluop;
    logic [2:0]  out_funct3;
`ifdef ID_STAGE_MEXT_EN
    logic        out_is_muldiv;
`endif

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_aluop(out_aluop), .out_imm(out_imm), .out_use_imm(out_use_imm),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
        .out_funct3(out_funct3),
`ifdef ID_STAGE_MEXT_EN
        .out_is_muldiv(out_is_muldiv),
`endif
        .out_illegal(out_illegal)
    );

    // Regfile: synchronous read, holds data when not enabled. Contents fixed.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (re1) rdata1 <= regs[raddr1];
        if (re2) rdata2 <= regs[raddr2];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic        rd_we;
        logic [3:0]  aluop;
        logic [31:0] imm;
        logic        use_imm, rs1u, rs2u, ld, st, br, jp, ill, md;
    } dec_t;

    // ALU code for funct7=0 forms, indexed by funct3.
    logic [3:0] base_alu [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [3:0] A_SUB = 4'd1, A_SRA = 4'd7;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return 32'($signed(w) >>> 20);
    endfunction
    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return 32'(($signed(w) >>> 25) * 32 + int'(w[11:7]));
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return 32'(($signed(w) >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return 32'(($signed(w) >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
    endfunction

    function automatic dec_t model_dec(input logic [31:0] w);
        dec_t d;
        logic [6:0] f7;
        logic [2:0] f3;
        d  = '0;
        f7 = w[31:25];
        f3 = w[14:12];
        case (w[6:0])
            7'h37, 7'h17: begin d.rd_we = 1; d.use_imm = 1; d.imm = w & 32'hFFFFF000; end
            7'h6F: begin d.jp = 1; d.rd_we = 1; d.use_imm = 1; d.imm = imm_j(w); end
            7'h67: begin d.jp = 1; d.rs1u = 1; d.rd_we = 1; d.use_imm = 1; d.imm = imm_i(w); end
            7'h63: begin d.br = 1; d.rs1u = 1; d.rs2u = 1; d.imm = imm_b(w); d.aluop = A_SUB; end
            7'h03: begin d.ld = 1; d.rs1u = 1; d.rd_we = 1; d.use_imm = 1; d.imm = imm_i(w); end
            7'h23: begin d.st = 1; d.rs1u = 1; d.rs2u = 1; d.use_imm = 1; d.imm = imm_s(w); end
            7'h13: begin
                d.rs1u = 1; d.rd_we = 1; d.use_imm = 1; d.imm = imm_i(w);
                d.aluop = base_alu[f3];
                if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1;
                if (f3 == 3'd5 && f7 == 7'h20) d.aluop = A_SRA;
                if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) d.ill = 1;
            end
            7'h33: begin
                d.rs1u = 1; d.rs2u = 1; d.rd_we = 1;
                if (f7 == 7'h00) d.aluop = base_alu[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) d.aluop = A_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) d.aluop = A_SRA;
`ifdef ID_STAGE_MEXT_EN
                else if (f7 == 7'h01) begin d.md = 1; d.aluop = {1'b0, f3}; end
`endif
                else d.ill = 1;
            end
            7'h0F: d.aluop = 4'd0;
            7'h73: if (w != 32'h00000073 && w != 32'h00100073) d.ill = 1;
            default: d.ill = 1;
        endcase
        if (d.ill) begin
            d = '0;
            d.ill = 1;
        end
        if (w[11:7] == 5'd0) d.rd_we = 0;
        return d;
    endfunction

    // Model of the output slot
    logic        m_valid = 0;
    logic [31:0] m_inst, m_pc, m_op1, m_op2;
    dec_t        m_dec;

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] inst, input logic ordy);
        rst = r; flush = f; in_valid = iv; in_inst = inst; out_ready = ordy;
        #1;
    endtask

    task automatic check_slot();
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_rs1", out_rs1, m_inst[19:15]);
            chk("out_rs2", out_rs2, m_inst[24:20]);
            chk("out_rd", out_rd, m_inst[11:7]);
            chk("out_funct3", out_funct3, m_inst[14:12]);
            chk("out_rd_we", out_rd_we, m_dec.rd_we);
            chk("out_aluop", out_aluop, m_dec.aluop);
            chk("out_imm", out_imm, m_dec.imm);
            chk("out_use_imm", out_use_imm, m_dec.use_imm);
            chk("out_op1", out_op1, m_op1);
            chk("out_op2", out_op2, m_op2);
            chk("class", {out_is_load, out_is_store, out_is_branch, out_is_jump},
                {m_dec.ld, m_dec.st, m_dec.br, m_dec.jp});
            chk("out_illegal", out_illegal, m_dec.ill);
`ifdef ID_STAGE_MEXT_EN
            chk("out_is_muldiv", out_is_muldiv, m_dec.md);
`endif
        end
    endtask

    // One cycle, starting and ending at a falling edge.
    task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] inst, input logic ordy);
        dec_t        d;
        logic        hz, rdy, acc;
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        in_pc = pc;
        drive(r, f, iv, inst, ordy);
        d   = model_dec(inst);
        hz  = m_valid && m_dec.ld && m_inst[11:7] != 0 &&
              ((d.rs1u && inst[19:15] == m_inst[11:7]) || (d.rs2u && inst[24:20] == m_inst[11:7]));
        rdy = !f && !hz && (!m_valid || ordy);
        acc = iv && rdy;
        chk("in_ready", in_ready, rdy);
        chk("re1", re1, acc && d.rs1u);
        chk("re2", re2, acc && d.rs2u);
        chk("raddr1", raddr1, inst[19:15]);
        chk("raddr2", raddr2, inst[24:20]);
        @(posedge clk);
        if (r || f) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_inst = inst; m_pc = pc; m_dec = d;
            m_op1 = d.rs1u ? regs[inst[19:15]] : 32'd0;
            m_op2 = d.rs2u ? regs[inst[24:20]] : 32'd0;
        end else if (ordy || !m_valid) m_valid = 0;
        @(negedge clk);
        check_slot();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] hi;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        hi  = $urandom;
        case ($urandom_range(0, 4))
            0, 1: f7 = 7'h00;
            2: f7 = 7'h20;
            3: f7 = 7'h01;
            default: f7 = hi[31:25];
        endcase
        case ($urandom_range(0, 13))
            0:  return {hi[31:12], rd, 7'b0110111};
            1:  return {hi[31:12], rd, 7'b0010111};
            2:  return {hi[31:12], rd, 7'b1101111};
            3:  return {hi[31:20], rs1, 3'b000, rd, 7'b1100111};
            4:  return {hi[31:25], rs2, rs1, f3, hi[11:7], 7'b1100011};
            5, 6: return {hi[31:20], rs1, f3, rd, 7'b0000011};
            7:  return {hi[31:25], rs2, rs1, f3, hi[11:7], 7'b0100011};
            8:  return {f7, hi[24:20], rs1, f3, rd, 7'b0010011};
            9, 10: return {f7, rs2, rs1, f3, rd, 7'b0110011};
            11: return 32'h0FF0000F;
            12: return hi[0] ? 32'h00100073 : 32'h00000073;
            default: return hi;
        endcase
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] LW   = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] ADD  = 32'h001101B3;  // add  x3,x2,x1
    localparam logic [31:0] XORI = 32'h0020C233;  // xor  x4,x1,x2
    localparam logic [31:0] MUL  = 32'h027302B3;  // mul  x5,x6,x7

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
        rst = 1; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        @(negedge clk);

        // Reset
        step(1, 0, 0, 32'd0, 1);
        step(1, 0, 0, 32'd0, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst fields", {out_pc, out_imm, out_op1, out_op2} == '0, 1);
        chk("rst regs", {out_rs1, out_rs2, out_rd, out_aluop, out_funct3}, 0);
        chk("rst flags", {out_rd_we, out_use_imm, out_is_load, out_is_store,
                          out_is_branch, out_is_jump, out_illegal}, 0);
        chk("rst re", {re1, re2}, 0);

        // addi
        step(0, 0, 1, ADDI, 1);
        chk("addi valid", out_valid, 1);
        chk("addi rd", out_rd, 1);
        chk("addi rd_we", out_rd_we, 1);
        chk("addi imm", out_imm, 5);
        chk("addi use_imm", out_use_imm, 1);
        chk("addi op1", out_op1, 0);

        // Load-use: exactly one stall and one bubble
        step(0, 0, 1, LW, 1);
        drive(0, 0, 1, ADD, 1);
        chk("lu stall ready", in_ready, 0);
        step(0, 0, 1, ADD, 1);
        chk("lu bubble", out_valid, 0);
        drive(0, 0, 1, ADD, 1);
        chk("lu resume ready", in_ready, 1);
        step(0, 0, 1, ADD, 1);
        chk("lu add valid", out_valid, 1);
        chk("lu add rs1", out_rs1, 2);
        chk("lu add rs2", out_rs2, 1);
        chk("lu add op1", out_op1, regs[2]);

        // Back-pressure for 3 cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, XORI, 0);
            chk("bp re", {re1, re2}, 0);
            step(0, 0, 1, XORI, 0);
            chk("bp hold rd", out_rd, 3);
        end
        step(0, 0, 1, XORI, 1);
        chk("bp accept rd", out_rd, 4);

        // Flush
        drive(0, 1, 1, ADDI, 1);
        chk("flush ready", in_ready, 0);
        chk("flush re", {re1, re2}, 0);
        step(0, 1, 1, ADDI, 1);
        chk("flush valid", out_valid, 0);

        // Illegal encodings
        step(0, 0, 1, 32'hFFFFFFFF, 1);
        chk("ill ones", {out_illegal, out_rd_we}, 2'b10);
        step(0, 0, 1, 32'h00500091, 1);
        chk("ill lowbits", {out_illegal, out_rd_we}, 2'b10);

        // RV32M
        step(0, 0, 1, MUL, 1);
        chk("mul rd", out_rd, 5);
`ifdef ID_STAGE_MEXT_EN
        chk("mul muldiv", {out_is_muldiv, out_illegal}, 2'b10);
`else
        chk("mul illegal", out_illegal, 1);
`endif

        // Reset in the middle of a load-use stall
        step(0, 0, 1, LW, 1);
        step(0, 0, 1, ADD, 0);
        step(1, 0, 1, ADD, 0);
        chk("midrst valid", out_valid, 0);
        drive(0, 0, 1, ADD, 1);
        chk("midrst ready", in_ready, 1);
        step(0, 0, 1, ADD, 1);
        chk("midrst reissue", out_rd, 3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) < 80, rand_inst(), $urandom_range(0, 99) < 70);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I instruction-decode stage, directly upstream of the register file and feeding the ID/EX boundary.
- Accepts one instruction per cycle from IF/ID and drives the regfile read ports (re1/re2/raddr1/raddr2).
- Registers the decoded control alongside the synchronously-read operands, which arrive one edge later.
- Presents a valid/ready output to EX, detects load-use hazards against its own output slot, and supports flush.

Parameters:
XLEN, 32, datapath and operand width
REG_AW, 5, register address width
ALUOP_W, 4, ALU opcode field width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  branch/exception flush; kills the output slot and the incoming instruction
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts in_inst this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
re1  out  1  regfile read enable 1
re2  out  1  regfile read enable 2
raddr1  out  REG_AW  rs1 address
raddr2  out  REG_AW  rs2 address
rdata1  in  XLEN  regfile read data 1, valid the edge after re1
rdata2  in  XLEN  regfile read data 2
out_valid  out  1  ID/EX slot holds an instruction
out_ready  in  1  EX consumes the slot
out_pc  out  XLEN  registered PC
out_rs1, out_rs2  out  REG_AW  source addresses, for EX forwarding
out_rd  out  REG_AW  destination
out_rd_we  out  1  writes rd; forced 0 when rd==0
out_aluop  out  ALUOP_W  ALU operation
out_imm  out  XLEN  sign-extended immediate
out_use_imm  out  1  operand 2 is the immediate
out_op1, out_op2  out  XLEN  operands: rdata masked to 0 when the rs is unused
out_is_load, out_is_store, out_is_branch, out_is_jump  out  1  class flags
out_funct3  out  3  memory width / branch condition
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset: out_valid=0; every out_* field is 0; rs-used flags are cleared.
- Handshake and acceptance:
  - accept = in_valid & in_ready.
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
- Regfile read timing:
  - raddr1/raddr2 are combinational from in_inst[19:15]/[24:20].
  - re1 = accept & rs1_used; re2 = accept & rs2_used.
  - The regfile captures on the same edge that loads the out register, so rdata is aligned with the slot.
  - When re is low the regfile holds its data, so the operands stay stable while the slot is stalled.
- Operands:
  - out_op1 = rs1_used_q ? rdata1 : 0; out_op2 is formed the same way.
  - The rs*_used_q flags are internal registers.
- Slot update at the clock edge:
  - accept: load the decode result; out_valid=1.
  - else if out_ready, or out_valid==0: out_valid=0 (bubble).
  - else: hold all fields.
- Load-use hazard:
  - hazard = out_valid & out_is_load & out_rd!=0 & ((rs1_used & rs1==out_rd) | (rs2_used & rs2==out_rd)).
  - Stall exactly one cycle. The load drains when out_ready is high, a bubble is inserted, and the dependent instruction is accepted the next cycle.
- Flush: synchronous. out_valid←0, in_ready=0, re1/re2=0 that cycle. Flush has priority over accept and hold.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (decoded as a NOP with rd_we=0), SYSTEM ECALL/EBREAK (class flags 0, rd_we=0).
- Immediates: I/S/B/U/J immediates are sign-extended to XLEN.
- Illegal encodings:
  - Covers any other opcode, a bad funct7 on OP/shift, and in_inst[1:0]!=2'b11.
  - Response: out_illegal=1, rd_we=0, all class flags 0.
- Rules for x0:
  - rd==0 gives out_rd_we=0.
  - rs==x0 counts as used, but the hazard compare excludes rd==0.
- Reset mid-stall: out_valid is cleared; the upstream instruction is re-presented by IF.

Optional Feature:
- Macro: ID_STAGE_MEXT_EN.
- Defined: OP with funct7=0000001 decodes the RV32M ops MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Added output out_is_muldiv (1 bit); out_aluop carries the M sub-op.
- Undefined: those encodings raise out_illegal=1, and out_is_muldiv is absent.

Decomposition:
- Shared package/define header (alongside the existing defines):
  - opcode constants and ALUOP encodings
  - funct3 codes for memory and branch
  - the illegal/enable level constants
- Sub-module id_imm_gen: combinational immediate generation from inst plus an immediate type.
- The main module holds the decoder, hazard logic and slot register.

Test Plan:
- Reset: rst=1 for 2 cycles → out_valid=0, all out_*=0, re1=re2=0.
- addi x1,x0,5 (0x00500093) with out_ready=1:
  - next cycle out_valid=1, out_rd=1, out_rd_we=1, out_imm=5, out_use_imm=1, out_op1=0.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3), out_ready=1:
  - in_ready=0 for exactly one cycle, one bubble cycle with out_valid=0.
  - add then issues with out_rs1=2, out_rs2=1.
- out_ready=0 for 3 cycles with the slot full:
  - all out_* held, re1=re2=0, rdata stable.
  - after out_ready=1, the next instruction is accepted.
- Flush:
  - flush=1 with out_valid=1 and in_valid=1 → next cycle out_valid=0, no read enables.
  - in_inst=0xFFFFFFFF gives out_illegal=1, out_rd_we=0.
- mul x5,x6,x7 (0x027302B3):
  - with ID_STAGE_MEXT_EN: out_is_muldiv=1, out_rd=5.
  - without: out_illegal=1.
